sopc_bus_arbiter: RTL and testbench
===================================

Name: sopc_bus_arbiter

Overview:
Arbitrates the SOPC's single-port memory bus between two masters: the instruction-fetch port (m0) and the load/store data port (m1).
- Sequences each transfer through a grant/wait/ack state machine with a bounded timeout.
- Applies data-first priority with an anti-starvation limit for fetch.
- Raises stall_req to the pipeline control unit while any master is waiting.
- Sits between the CPU core and the instruction/data RAM inside the SOPC top level.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 15, bus cycles without s_ack before the transfer is aborted (range 1..255)
STARVE_LIMIT, 4, consecutive m1 grants while m0_req is pending before m0 is forced a grant (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  fetch request; held with m0_addr until m0_ack
m0_addr  in  ADDR_W  fetch address
m0_rdata  out  DATA_W  fetch read data, valid when m0_ack=1
m0_ack  out  1  one-cycle completion pulse
m1_req  in  1  data request; held with fields until m1_ack
m1_we  in  1  1=write
m1_sel  in  4  byte enables
m1_addr  in  ADDR_W  data address
m1_wdata  in  DATA_W  write data
m1_rdata  out  DATA_W  read data, valid when m1_ack=1
m1_ack  out  1  one-cycle completion pulse
s_cyc  out  1  bus cycle active
s_we  out  1  write strobe to slave
s_sel  out  4  byte enables to slave
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_rdata  in  DATA_W  slave read data
s_ack  in  1  slave completion, may arrive in any cycle while s_cyc=1
grant  out  2  current owner: 00 none, 01 m0, 10 m1
bus_err  out  1  one-cycle pulse on timeout abort
stall_req  out  1  to pipeline control; combinational

Behaviour:
- States: IDLE, BUS_I, BUS_D. All outputs are registered except stall_req.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; streak and timeout counters clear to 0.
  - All outputs go to 0: s_cyc, acks, rdata, grant, bus_err.
  - A transfer in flight is abandoned with no ack.
- IDLE arbitration uses masked requests: eff_mX = mX_req & ~mX_ack.
  - A request held through its own ack cycle counts as a new request from the following cycle.
  - If eff_m1 and not (eff_m0 and streak==STARVE_LIMIT): go to BUS_D.
  - Else if eff_m0: go to BUS_I.
  - Otherwise stay in IDLE.
- Streak counter:
  - Increments on each BUS_D entry while m0_req=1, saturating at STARVE_LIMIT.
  - Clears on BUS_I entry, and whenever m0_req=0 in IDLE.
- Entering BUS_x:
  - s_cyc=1; s_we, s_sel, s_addr, s_wdata are registered from the owner.
  - For m0: s_we=0, s_sel=4'hF, s_wdata=0.
  - grant reflects the owner; the timeout counter clears.
- In BUS_x with s_ack=1:
  - Owner rdata <= s_rdata; owner ack=1 for one cycle.
  - s_cyc=0, grant=00, go to IDLE.
- In BUS_x with s_ack=0: the counter increments. When counter==TIMEOUT-1 and still no ack:
  - Owner ack=1 with rdata=0; bus_err=1 for one cycle.
  - Go to IDLE; s_cyc drops.
- Minimum latency: req in IDLE at cycle 0 -> s_cyc at 1 -> s_ack at 1 -> ack at 2. Back-to-back transfers have one idle cycle between them.
- s_ack while s_cyc=0 is ignored.
- stall_req = (m0_req & ~m0_ack) | (m1_req & ~m1_ack).
- rdata outputs hold their last value between acks.

Decomposition:
- Package sopc_bus_pkg holds:
  - State encoding (IDLE/BUS_I/BUS_D).
  - GRANT_NONE/GRANT_I/GRANT_D constants.
  - Default ADDR_W/DATA_W.
- One sub-module, bus_timeout_timer: clear/enable inputs, parameter TIMEOUT, expire output. Instantiated once.

Test Plan:
- m0_req only, addr 0x0000_0004, s_ack one cycle after s_cyc with s_rdata 0x3401_1100 -> s_addr 0x4, s_we=0, m0_ack at cycle 3 with m0_rdata 0x3401_1100, grant 01 then 00, stall_req high cycles 0-2.
- m0_req and m1_req rise together; m1 write 0x8 data 0xDEADBEEF sel 4'hF -> m1 served first (s_we=1, s_wdata 0xDEADBEEF), then m0 after one idle cycle.
- m1_req held continuously, m0_req held, immediate s_ack -> after 4 m1 grants the 5th grant goes to m0; streak then restarts.
- s_ack never asserted, TIMEOUT=15 -> ack and bus_err pulse together 15 cycles after s_cyc rose, rdata=0, state IDLE.
- reset driven low mid-BUS_D, asynchronously between edges -> s_cyc, grant, acks go to 0 immediately; no m1_ack; after release m1_req is re-arbitrated normally.
- Spurious s_ack in IDLE with no requests -> no ack, rdata unchanged, grant 00.

Source files
------------

// File: rtl/sopc_bus_pkg.sv
// Shared types and constants for the SOPC two-master memory bus arbiter.
// Holds the arbiter state encoding, grant codes and default bus widths.
package sopc_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS_I = 2'd1,
        ST_BUS_D = 2'd2
    } bus_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/bus_timeout_timer.sv
// Counts bus cycles without a slave ack; expire is combinational from the count
// and fires in the cycle where TIMEOUT-1 cycles have already elapsed with enable held.
module bus_timeout_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/sopc_bus_arbiter.sv
// Arbitrates the single-port memory bus between fetch (m0) and load/store (m1), data first.
// Grant one cycle after request, ack one cycle after s_ack or timeout; masters hold req until ack.
module sopc_bus_arbiter
    import sopc_bus_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_sel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              s_cyc,
    output logic              s_we,
    output logic [3:0]        s_sel,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ack,
    output logic [1:0]        grant,
    output logic              bus_err,
    output logic              stall_req
);

    bus_state_t state, next_state;
    logic [3:0] streak;
    logic       eff_m0, eff_m1, starve, in_bus, expire, done;

    // A request is hidden during its own ack cycle so a held req reads as a fresh one next cycle.
    assign eff_m0    = m0_req & ~m0_ack;
    assign eff_m1    = m1_req & ~m1_ack;
    assign starve    = eff_m0 && (streak == 4'(STARVE_LIMIT));
    assign in_bus    = (state != ST_IDLE);
    assign done      = in_bus && (s_ack || expire);
    assign stall_req = eff_m0 | eff_m1;

    bus_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (reset),
        .clear (!in_bus),
        .enable(in_bus && !s_ack),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (eff_m1 && !starve) begin
                    next_state = ST_BUS_D;
                end else if (eff_m0) begin
                    next_state = ST_BUS_I;
                end
            end
            ST_BUS_I, ST_BUS_D: begin
                if (done) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Counts data grants that overtook a pending fetch; any fetch grant or idle fetch port resets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (state == ST_IDLE) begin
            if (next_state == ST_BUS_I || !m0_req) begin
                streak <= '0;
            end else if (next_state == ST_BUS_D && streak != 4'(STARVE_LIMIT)) begin
                streak <= streak + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cyc    <= 1'b0;
            s_we     <= 1'b0;
            s_sel    <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            grant    <= GRANT_NONE;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            bus_err  <= 1'b0;
        end else begin
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            bus_err <= 1'b0;
            if (state == ST_IDLE && next_state == ST_BUS_I) begin
                s_cyc   <= 1'b1;
                s_we    <= 1'b0;
                s_sel   <= 4'hF;
                s_addr  <= m0_addr;
                s_wdata <= '0;
                grant   <= GRANT_I;
            end else if (state == ST_IDLE && next_state == ST_BUS_D) begin
                s_cyc   <= 1'b1;
                s_we    <= m1_we;
                s_sel   <= m1_sel;
                s_addr  <= m1_addr;
                s_wdata <= m1_wdata;
                grant   <= GRANT_D;
            end else if (done) begin
                s_cyc   <= 1'b0;
                grant   <= GRANT_NONE;
                bus_err <= !s_ack;
                if (state == ST_BUS_I) begin
                    m0_ack   <= 1'b1;
                    m0_rdata <= s_ack ? s_rdata : '0;
                end else begin
                    m1_ack   <= 1'b1;
                    m1_rdata <= s_ack ? s_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
// Randomized scoreboard bench for sopc_bus_arbiter: a transaction-level model predicts
// each grant and its ack cycle; a monitor compares the DUT against the queued expectations.
module tb_sopc_bus_arbiter;

    localparam int TO = 15;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req = 1'b0;
    logic        m1_we = 1'b0;
    logic [3:0]  m1_sel = '0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic        s_cyc, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = '0;
    logic        s_ack = 1'b0;
    logic [1:0]  grant;
    logic        bus_err, stall_req;

    always #5 clk = ~clk;

    sopc_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_cyc(s_cyc), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant), .bus_err(bus_err),
        .stall_req(stall_req)
    );

    typedef struct { logic [31:0] addr; logic we; logic [3:0] sel; logic [31:0] wdata; int at; } txn_t;
    typedef struct { int cyc; logic [1:0] grant; logic [31:0] addr; logic we; logic [3:0] sel; logic [31:0] wdata; } start_t;
    typedef struct { int cyc; logic [31:0] rdata; logic err; } ack_t;
    typedef struct { int d; logic [31:0] rd; } resp_t;

    txn_t   dq0[$], dq1[$];
    resp_t  dd[$];
    start_t qs[$];
    ack_t   qa0[$], qa1[$];
    txn_t   tx0, tx1;
    bit     act0 = 0, act1 = 0, rnd_en = 0, spur_all = 0;
    int     cyc = 0, n_cmp = 0, n_err = 0, rst_count = 0;
    int     cur_owner = 0, cur_start = 0, cur_end = 0, cur_d = 0, streak = 0;
    logic [31:0] cur_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [3:0] s,
                                input logic [31:0] d, input int at);
        txn_t t;
        t.addr = a; t.we = w; t.sel = s; t.wdata = d; t.at = at;
        return t;
    endfunction

    function automatic resp_t mk_resp(input int d, input logic [31:0] rd);
        resp_t r;
        r.d = d; r.rd = rd;
        return r;
    endfunction

    function automatic txn_t rand_txn();
        return mk($urandom, 1'($urandom), 4'($urandom), $urandom, 0);
    endfunction

    // Predicts the arbitration outcome for the next edge and, when a transfer starts,
    // decides the slave's response and queues the resulting start and ack expectations.
    task automatic model_step(input bit a0, input bit a1);
        bit eff0, eff1;
        int own, k;
        resp_t r;
        start_t s;
        ack_t a;
        if (cur_owner != 0 && cyc < cur_end) return;
        eff0 = m0_req && !a0;
        eff1 = m1_req && !a1;
        if (eff1 && !(eff0 && streak == SL)) begin
            own = 2;
            streak = m0_req ? ((streak < SL) ? streak + 1 : SL) : 0;
        end else if (eff0) begin
            own = 1;
            streak = 0;
        end else begin
            if (!m0_req) streak = 0;
            return;
        end
        if (dd.size() > 0) begin
            r = dd.pop_front();
        end else begin
            k = $urandom_range(0, 15);
            r.rd = $urandom;
            r.d = (k <= 10) ? k % 4 : (k == 11) ? TO - 1 : (k == 12) ? TO : (k == 13) ? 255 : 0;
        end
        cur_owner = own;
        cur_start = cyc + 1;
        cur_d     = r.d;
        cur_rd    = r.rd;
        cur_end   = cur_start + ((r.d < TO) ? r.d + 1 : TO);
        s.cyc = cur_start;
        s.grant = 2'(own);
        if (own == 1) begin
            s.addr = tx0.addr; s.we = 1'b0; s.sel = 4'hF; s.wdata = '0;
        end else begin
            s.addr = tx1.addr; s.we = tx1.we; s.sel = tx1.sel; s.wdata = tx1.wdata;
        end
        qs.push_back(s);
        a.cyc = cur_end;
        a.err = (r.d >= TO);
        a.rdata = a.err ? 32'h0 : r.rd;
        if (own == 1) qa0.push_back(a);
        else qa1.push_back(a);
    endtask

    task automatic tick();
        bit a0, a1;
        @(negedge clk);
        a0 = (cur_owner == 1) && (cyc == cur_end);
        a1 = (cur_owner == 2) && (cyc == cur_end);
        if (act0 && a0) act0 = 0;
        if (act1 && a1) act1 = 0;
        if (!act0) begin
            if (dq0.size() > 0) begin
                if (cyc >= dq0[0].at) begin tx0 = dq0.pop_front(); act0 = 1; end
            end else if (rnd_en && $urandom_range(0, 2) == 0) begin
                tx0 = rand_txn(); act0 = 1;
            end
        end
        if (!act1) begin
            if (dq1.size() > 0) begin
                if (cyc >= dq1[0].at) begin tx1 = dq1.pop_front(); act1 = 1; end
            end else if (rnd_en && $urandom_range(0, 2) == 0) begin
                tx1 = rand_txn(); act1 = 1;
            end
        end
        m0_req = act0; m0_addr = tx0.addr;
        m1_req = act1; m1_we = tx1.we; m1_sel = tx1.sel; m1_addr = tx1.addr; m1_wdata = tx1.wdata;
        if (cur_owner != 0 && cyc >= cur_start && cyc < cur_end) begin
            s_ack = (cyc == cur_start + cur_d);
            s_rdata = s_ack ? cur_rd : $urandom;
        end else begin
            s_ack = spur_all || ($urandom_range(0, 7) == 0);
            s_rdata = $urandom;
        end
        model_step(a0, a1);
    endtask

    initial begin : monitor
        logic [31:0] hold0, hold1;
        int seen_rst;
        bit e0, e1, exp_err, exp_scyc;
        ack_t a;
        start_t s;
        hold0 = '0; hold1 = '0; seen_rst = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (seen_rst != rst_count) begin hold0 = '0; hold1 = '0; seen_rst = rst_count; end
            e0 = (qa0.size() > 0) && (qa0[0].cyc == cyc);
            e1 = (qa1.size() > 0) && (qa1[0].cyc == cyc);
            exp_err = 0;
            chk("m0_ack", 32'(m0_ack), 32'(e0));
            if (e0) begin
                a = qa0.pop_front();
                chk("m0_rdata", m0_rdata, a.rdata);
                hold0 = a.rdata; exp_err = exp_err | a.err;
            end else chk("m0_rdata_hold", m0_rdata, hold0);
            chk("m1_ack", 32'(m1_ack), 32'(e1));
            if (e1) begin
                a = qa1.pop_front();
                chk("m1_rdata", m1_rdata, a.rdata);
                hold1 = a.rdata; exp_err = exp_err | a.err;
            end else chk("m1_rdata_hold", m1_rdata, hold1);
            chk("bus_err", 32'(bus_err), 32'(exp_err));
            exp_scyc = (cur_owner != 0) && (cyc >= cur_start) && (cyc < cur_end);
            chk("s_cyc", 32'(s_cyc), 32'(exp_scyc));
            chk("grant", 32'(grant), exp_scyc ? 32'(cur_owner) : 32'h0);
            if (qs.size() > 0 && qs[0].cyc == cyc) begin
                s = qs.pop_front();
                chk("s_addr", s_addr, s.addr);
                chk("s_we", 32'(s_we), 32'(s.we));
                chk("s_sel", 32'(s_sel), 32'(s.sel));
                chk("s_wdata", s_wdata, s.wdata);
            end
            chk("stall_req", 32'(stall_req), 32'((m0_req && !e0) || (m1_req && !e1)));
        end
    end

    initial begin
        dq0.push_back(mk(32'h0000_0004, 1'b0, 4'hF, 32'h0, 3));
        dd.push_back(mk_resp(1, 32'h3401_1100));
        dq0.push_back(mk(32'h0000_0100, 1'b0, 4'hF, 32'h0, 12));
        dq1.push_back(mk(32'h0000_0008, 1'b1, 4'hF, 32'hDEAD_BEEF, 12));
        dd.push_back(mk_resp(0, 32'h0));
        dd.push_back(mk_resp(0, 32'h5A5A_0001));
        dq1.push_back(mk(32'h0000_0020, 1'b0, 4'h3, 32'h0, 22));
        dd.push_back(mk_resp(255, 32'h0));

        repeat (3) tick();
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_acks", 32'({m0_ack, m1_ack, bus_err}), 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        reset = 1'b1;

        repeat (45) tick();
        rnd_en = 1;
        repeat (2000) tick();
        rnd_en = 0;
        for (int i = 0; i < 300 && (act0 || act1); i++) tick();
        repeat (3) tick();
        chk("drain_idle", 32'(act0 || act1), 32'h0);

        // Abort an m1 transfer with an asynchronous reset between clock edges.
        dq1.push_back(mk(32'h0000_0040, 1'b1, 4'hC, 32'h1234_5678, 0));
        dd.push_back(mk_resp(255, 32'h0));
        for (int i = 0; i < 20 && !(cur_owner == 2 && cyc >= cur_start + 2 && cyc < cur_end); i++) tick();
        chk("pre_rst_s_cyc", 32'(s_cyc), 32'h1);
        chk("pre_rst_grant", 32'(grant), 32'h2);
        #2 reset = 1'b0;
        #1;
        chk("async_s_cyc", 32'(s_cyc), 32'h0);
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_acks", 32'({m0_ack, m1_ack, bus_err}), 32'h0);
        chk("async_rdata", m1_rdata, 32'h0);
        qs.delete(); qa0.delete(); qa1.delete();
        cur_owner = 0; cur_end = 0; streak = 0; rst_count++;
        #1 reset = 1'b1;
        dd.push_back(mk_resp(0, 32'hCAFE_F00D));
        model_step(1'b0, 1'b0);
        for (int i = 0; i < 30 && act1; i++) tick();
        repeat (2) tick();
        chk("rearb_done", 32'(act1), 32'h0);

        spur_all = 1;
        repeat (10) tick();
        spur_all = 0;
        repeat (2) tick();
        chk("spurious_rdata", m1_rdata, 32'hCAFE_F00D);
        chk("leftover_expect", 32'(qa0.size() + qa1.size() + qs.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
